// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the synchronous FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // True when both thresholds fall inside the range a FIFO of this depth can report.
  function automatic bit thresholds_ok(input int unsigned depth,
                                       input int unsigned af_level,
                                       input int unsigned ae_level);
    return (af_level >= 1) && (af_level <= depth) && (ae_level < depth);
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer bus of the synchronous FIFO: write side, read side, status and errors.
interface sync_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 3
);

  logic                  w_en;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [PTR_WIDTH:0]    count;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  modport master (
    output w_en, w_data, r_en, clr_err,
    input  r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, w_data, r_en, clr_err,
    output r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write, unregistered read address path.
module sync_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << PTR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, thresholds, sticky errors and
// either a registered read port or a first-word-fall-through head.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 3,
  parameter int unsigned FWFT       = FIFO_MODE_STD,
  parameter int unsigned AF_LEVEL   = (1 << PTR_WIDTH) - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  sync_fifo_ctrl_if.slave bus
);

  localparam int unsigned DEPTH = 1 << PTR_WIDTH;
  localparam int unsigned CW    = PTR_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (!thresholds_ok(DEPTH, AF_LEVEL, AE_LEVEL) || (FWFT > FIFO_MODE_FWFT)) begin : g_bad_params
    $error("sync_fifo_ctrl: AF_LEVEL, AE_LEVEL or FWFT outside the legal range");
  end

  logic [CW-1:0]         wr_ptr;
  logic [CW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_next;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  full_q;
  logic                  empty_q;
  logic                  af_q;
  logic                  ae_q;
  logic                  ovf_q;
  logic                  udf_q;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Acceptance is judged against registered state only.
  always_comb begin
    wr_acc   = bus.w_en & ~full_q;
    rd_acc   = bus.r_en & ~empty_q;
    cnt_next = cnt + CW'(wr_acc) - CW'(rd_acc);
  end

  // Pointers wrap naturally; the extra MSB toggles each pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + CW'(1);
      cnt     <= cnt_next;
      full_q  <= (cnt_next == DEPTH_C);
      empty_q <= (cnt_next == '0);
      af_q    <= (cnt_next >= AF_C);
      ae_q    <= (cnt_next <= AE_C);
    end
  end

  // Sticky errors; a new error in the clearing cycle wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~bus.clr_err) | (bus.w_en & full_q);
      udf_q <= (udf_q & ~bus.clr_err) | (bus.r_en & empty_q);
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[PTR_WIDTH-1:0]),
    .wdata (bus.w_data),
    .raddr (rd_ptr[PTR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word is presented directly; only meaningful while not empty.
    assign bus.r_data = ram_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data_q <= '0;
      end else if (rd_acc) begin
        r_data_q <= ram_rdata;
      end
    end

    assign bus.r_data = r_data_q;
  end

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench driving a standard-read and an FWFT instance with identical stimulus.
module tb_sync_fifo_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.DATA_WIDTH(8), .PTR_WIDTH(3)) bus_std ();
  sync_fifo_ctrl_if #(.DATA_WIDTH(8), .PTR_WIDTH(3)) bus_fwft ();

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .PTR_WIDTH(3), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)
  ) u_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_std)
  );

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .PTR_WIDTH(3), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2)
  ) u_fwft (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fwft)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] sb[$];
  logic [7:0] last_std;
  bit         m_ovf;
  bit         m_udf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit we, input logic [7:0] wd, input bit re, input bit clr);
    bus_std.w_en     = we;
    bus_std.w_data   = wd;
    bus_std.r_en     = re;
    bus_std.clr_err  = clr;
    bus_fwft.w_en    = we;
    bus_fwft.w_data  = wd;
    bus_fwft.r_en    = re;
    bus_fwft.clr_err = clr;
  endtask

  // Compare both instances against the scoreboard-derived status.
  task automatic check_state(input string ph);
    int n;
    n = sb.size();
    check({ph, ":count_std"},  32'(bus_std.count),         32'(n));
    check({ph, ":count_fwft"}, 32'(bus_fwft.count),        32'(n));
    check({ph, ":full_std"},   32'(bus_std.full),          32'(n == 8));
    check({ph, ":full_fwft"},  32'(bus_fwft.full),         32'(n == 8));
    check({ph, ":empty_std"},  32'(bus_std.empty),         32'(n == 0));
    check({ph, ":empty_fwft"}, 32'(bus_fwft.empty),        32'(n == 0));
    check({ph, ":af_std"},     32'(bus_std.almost_full),   32'(n >= 6));
    check({ph, ":af_fwft"},    32'(bus_fwft.almost_full),  32'(n >= 6));
    check({ph, ":ae_std"},     32'(bus_std.almost_empty),  32'(n <= 2));
    check({ph, ":ae_fwft"},    32'(bus_fwft.almost_empty), 32'(n <= 2));
    check({ph, ":ovf_std"},    32'(bus_std.overflow),      32'(m_ovf));
    check({ph, ":ovf_fwft"},   32'(bus_fwft.overflow),     32'(m_ovf));
    check({ph, ":udf_std"},    32'(bus_std.underflow),     32'(m_udf));
    check({ph, ":udf_fwft"},   32'(bus_fwft.underflow),    32'(m_udf));
    check({ph, ":rdata_std"},  32'(bus_std.r_data),        32'(last_std));
    if (n != 0) check({ph, ":rdata_fwft"}, 32'(bus_fwft.r_data), 32'(sb[0]));
  endtask

  // One clock of stimulus; called and returns 1 time unit after a rising edge.
  task automatic step(input string ph, input bit we, input logic [7:0] wd,
                      input bit re, input bit clr);
    int n;
    bit wacc, racc;
    n    = sb.size();
    wacc = we && (n != 8);
    racc = re && (n != 0);
    m_ovf = (m_ovf && !clr) || (we && n == 8);
    m_udf = (m_udf && !clr) || (re && n == 0);
    drive(we, wd, re, clr);
    @(posedge clk);
    #1;
    if (racc) last_std = sb.pop_front();
    if (wacc) sb.push_back(wd);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check_state(ph);
  endtask

  task automatic model_reset();
    sb.delete();
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    last_std = 8'h00;
  endtask

  // Reset lands in the middle of a write burst and must take effect without a clock.
  task automatic async_reset_mid_burst();
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("rst_async");
    @(posedge clk);
    #1;
    check_state("rst_held");
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst_n = 1'b1;

    // Fill 0x01..0x08, then one write too many.
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    step("ovf_write", 1'b1, 8'h09, 1'b0, 1'b0);
    step("clr_ovf", 1'b0, 8'h00, 1'b0, 1'b1);

    // Drain in order, then one read too many.
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("udf_read", 1'b0, 8'h00, 1'b1, 1'b0);
    step("clr_udf", 1'b0, 8'h00, 1'b0, 1'b1);

    // Single word falls through, then is popped.
    step("fwft_wr", 1'b1, 8'hA5, 1'b0, 1'b0);
    step("fwft_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    step("fwft_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Interleaved pairs around a level of three, crossing several wraps.
    for (int i = 0; i < 3; i++) step("wrap_pre", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom_range(0, 255));
      step("wrap_wr", 1'b1, d, 1'b0, 1'b0);
      step("wrap_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) step("wrap_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous read/write at full and at empty.
    for (int i = 0; i < 8; i++) step("sim_fill", 1'b1, 8'(8'h40 + 8'(i)), 1'b0, 1'b0);
    step("sim_full", 1'b1, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step("sim_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("sim_empty", 1'b1, 8'h77, 1'b1, 1'b0);
    step("sim_rd_next", 1'b0, 8'h00, 1'b1, 1'b0);
    step("sim_clr", 1'b0, 8'h00, 1'b0, 1'b1);

    // Clear versus a coincident new error, then reset mid-burst.
    step("udf_again", 1'b0, 8'h00, 1'b1, 1'b0);
    step("clr_vs_set", 1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step("burst", 1'b1, 8'(8'h90 + 8'(i)), 1'b0, 1'b0);
    async_reset_mid_burst();
    step("post_wr", 1'b1, 8'h3C, 1'b0, 1'b0);
    step("post_wr2", 1'b1, 8'h5A, 1'b0, 1'b0);
    step("post_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    step("post_rd2", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
